// File: rtl/axis_axi_burst_writer_pkg.sv
// rtl/axis_axi_burst_writer_pkg.sv - shared AXI constants and FSM encoding for the burst writer
package axis_axi_burst_writer_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;
  localparam state_t ST_RESP = 2'd3;

endpackage

// File: rtl/axis_axi_burst_writer_if.sv
// rtl/axis_axi_burst_writer_if.sv - config, stream and AXI write channels of the burst writer
interface axis_axi_burst_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 20
) ();

  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  error;

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  modport master (
    input  cfg_base_addr, cfg_len, start,
    output busy, done, error,
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output cfg_base_addr, cfg_len, start,
    input  busy, done, error,
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/axi_burst_len_calc.sv
// rtl/axi_burst_len_calc.sv - burst size = min(remaining words, max burst, words left in the 4 KB page)
module axi_burst_len_calc
  import axis_axi_burst_writer_pkg::*;
#(
  parameter int STRB_WIDTH    = 4,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 20
) (
  input  logic [LEN_WIDTH-1:0] i_remaining,
  input  logic [11:0]          i_addr_low,
  output logic [8:0]           o_burst
);

  localparam int SZ = $clog2(STRB_WIDTH);
  localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]   w_bytes_to_4k;
  logic [12:0]   w_words_to_4k;
  logic [12:0]   w_cap;
  logic [CW-1:0] w_remaining;
  logic [CW-1:0] w_cap_ext;

  // 13 bits so an address at the page start yields the full 4096 bytes
  assign w_bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, i_addr_low};
  assign w_words_to_4k = w_bytes_to_4k >> SZ;
  assign w_cap         = (w_words_to_4k < 13'(MAX_BURST_LEN)) ? w_words_to_4k : 13'(MAX_BURST_LEN);
  assign w_remaining   = CW'(i_remaining);
  assign w_cap_ext     = CW'(w_cap);
  assign o_burst       = (w_remaining < w_cap_ext) ? 9'(w_remaining) : 9'(w_cap);

endmodule

// File: rtl/axis_axi_burst_writer.sv
// rtl/axis_axi_burst_writer.sv - drains an AXI-Stream into memory as single-outstanding AXI4 INCR bursts
module axis_axi_burst_writer
  import axis_axi_burst_writer_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_axi_burst_writer_if.master bus
);

  localparam int SZ = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << SZ) - 1);

  if (ADDR_WIDTH < 12) begin : g_bad_addr_width
    $error("ADDR_WIDTH must be at least 12");
  end
  if ((STRB_WIDTH & (STRB_WIDTH - 1)) != 0) begin : g_bad_strb_width
    $error("STRB_WIDTH must be a power of two");
  end
  if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256) begin : g_bad_burst_len
    $error("MAX_BURST_LEN must be in 1..256");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [7:0]            r_beat_cnt;
  logic [8:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [8:0]            w_burst;
  logic                  w_wvalid;
  logic                  w_tready;
  logic                  w_wlast;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_last_burst;
  logic [ADDR_WIDTH-1:0] w_base_aligned;
  logic [ID_WIDTH-1:0]   w_unused_bid;

  axi_burst_len_calc #(
    .STRB_WIDTH    (STRB_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .LEN_WIDTH     (LEN_WIDTH)
  ) u_len_calc (
    .i_remaining (r_remaining),
    .i_addr_low  (r_addr[11:0]),
    .o_burst     (w_burst)
  );

  assign w_base_aligned = bus.cfg_base_addr & ~LOW_MASK;
  assign w_w_hs         = w_wvalid & bus.m_axi_wready;
  assign w_b_hs         = bus.m_axi_bvalid & r_bready;
  assign w_last_burst   = (r_remaining == LEN_WIDTH'(r_burst));
  assign w_unused_bid   = bus.m_axi_bid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start && bus.cfg_len != '0)   w_state_nxt = ST_ADDR;
      ST_ADDR: if (r_awvalid && bus.m_axi_awready)   w_state_nxt = ST_DATA;
      ST_DATA: if (w_w_hs && w_wlast)                w_state_nxt = ST_RESP;
      ST_RESP: if (w_b_hs) w_state_nxt = w_last_burst ? ST_IDLE : ST_ADDR;
      default:                                       w_state_nxt = ST_IDLE;
    endcase
  end

  // W channel is a zero-latency pass-through of the stream, only open in DATA
  always_comb begin
    w_wvalid = 1'b0;
    w_tready = 1'b0;
    w_wlast  = 1'b0;
    if (r_state == ST_DATA) begin
      w_wvalid = bus.s_axis_tvalid;
      w_tready = bus.m_axi_wready;
      w_wlast  = (r_beat_cnt == 8'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_beat_cnt  <= '0;
      r_burst     <= '0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_addr      <= w_base_aligned;
            r_remaining <= bus.cfg_len;
            r_error     <= 1'b0;
            if (bus.cfg_len == '0) r_done <= 1'b1;
            else                   r_busy <= 1'b1;
          end
        end
        ST_ADDR: begin
          // burst size is frozen with the AW beat so RESP advances by what was issued
          if (!r_awvalid) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= r_addr;
            r_awlen   <= 8'(w_burst - 9'd1);
            r_burst   <= w_burst;
          end else if (bus.m_axi_awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= r_awlen;
          end
        end
        ST_DATA: begin
          if (w_w_hs) begin
            if (w_wlast) r_bready   <= 1'b1;
            else         r_beat_cnt <= r_beat_cnt - 8'd1;
          end
        end
        ST_RESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            if (bus.m_axi_bresp != RESP_OKAY) r_error <= 1'b1;
            r_addr      <= r_addr + (ADDR_WIDTH'(r_burst) << SZ);
            r_remaining <= r_remaining - LEN_WIDTH'(r_burst);
            if (w_last_burst) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.error         = r_error;
  assign bus.s_axis_tready = w_tready;
  assign bus.m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awlen   = r_awlen;
  assign bus.m_axi_awsize  = 3'(SZ);
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awvalid = r_awvalid;
  assign bus.m_axi_wdata   = bus.s_axis_tdata;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = w_wlast;
  assign bus.m_axi_wvalid  = w_wvalid;
  assign bus.m_axi_bready  = r_bready;

endmodule

// File: tb/tb_axis_axi_burst_writer.sv
// tb/tb_axis_axi_burst_writer.sv - directed self-checking bench for axis_axi_burst_writer
module tb_axis_axi_burst_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  axis_axi_burst_writer_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8), .LEN_WIDTH(20)
  ) bus ();

  axis_axi_burst_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8),
    .AXI_ID(0), .MAX_BURST_LEN(16), .LEN_WIDTH(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0]  aw_addr_q[$];
  int           aw_len_q[$];
  int           wlast_q[$];
  logic [31:0]  mem[int];
  int           done_cnt;
  int           beats;
  int           cross_cnt;
  bit           saw_busy;
  bit           saw_awvalid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sdata(input logic [7:0] tag, input int k);
    return {tag, 8'h5A, 16'(k)};
  endfunction

  task automatic drive_idle();
    bus.cfg_base_addr = '0;
    bus.cfg_len       = '0;
    bus.start         = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bid     = '0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bvalid  = 1'b0;
  endtask

  // Acts as stream source and AXI RAM slave, one iteration per clock, until done has settled
  task automatic run_xfer(input logic [15:0] base, input int len, input logic [7:0] tag,
                          input bit gaps, input int bad_burst, input int stop_after);
    int sidx = 0;
    int beat = 0;
    int burst_idx = 0;
    int extra = 0;
    bit b_pend = 0;
    logic [15:0] cur = '0;
    aw_addr_q.delete(); aw_len_q.delete(); wlast_q.delete(); mem.delete();
    done_cnt = 0; beats = 0; cross_cnt = 0; saw_busy = 0; saw_awvalid = 0;
    @(negedge clk);
    bus.cfg_base_addr = base;
    bus.cfg_len       = 20'(len);
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.s_axis_tvalid = (sidx < len) && (!gaps || $urandom_range(0, 3) != 0);
      bus.s_axis_tdata  = (sidx < len) ? sdata(tag, sidx) : 32'h0;
      bus.m_axi_awready = !gaps || ($urandom_range(0, 1) != 0);
      bus.m_axi_wready  = !gaps || ($urandom_range(0, 2) != 0);
      bus.m_axi_bvalid  = b_pend;
      bus.m_axi_bresp   = (b_pend && burst_idx == bad_burst) ? 2'b10 : 2'b00;
      #1;
      if (bus.busy) saw_busy = 1;
      if (bus.m_axi_awvalid) saw_awvalid = 1;
      if (bus.done) done_cnt++;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_addr_q.push_back(bus.m_axi_awaddr);
        aw_len_q.push_back(int'(bus.m_axi_awlen));
        if (int'(bus.m_axi_awaddr[11:0]) + (int'(bus.m_axi_awlen) + 1) * 4 > 4096) cross_cnt++;
        cur = bus.m_axi_awaddr;
        beat = 0;
        burst_idx++;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        mem[int'(cur >> 2) + beat] = bus.m_axi_wdata;
        beat++;
        beats++;
        sidx++;
        if (bus.m_axi_wlast) begin
          wlast_q.push_back(beats);
          b_pend = 1;
        end
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 0;
      if (stop_after > 0 && beats == stop_after) return;
      if (done_cnt > 0) extra++;
      if (extra > 3) return;
      @(negedge clk);
    end
  endtask

  task automatic chk_mem(input string tag, input logic [15:0] base, input int len, input logic [7:0] dtag);
    int bad = 0;
    for (int k = 0; k < len; k++) begin
      int a = int'(base >> 2) + k;
      if (!mem.exists(a) || mem[a] !== sdata(dtag, k)) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("rst_bready", bus.m_axi_bready, 1'b0);
    chk("rst_wvalid", bus.m_axi_wvalid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Three bursts split by MAX_BURST_LEN
    run_xfer(16'h0000, 40, 8'h01, 0, 0, 0);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_naw", 32'(aw_addr_q.size()), 32'd3);
    chk("t1_aw0", 32'(aw_addr_q[0]), 32'h0000);
    chk("t1_len0", 32'(aw_len_q[0]), 32'd15);
    chk("t1_aw1", 32'(aw_addr_q[1]), 32'h0040);
    chk("t1_len1", 32'(aw_len_q[1]), 32'd15);
    chk("t1_aw2", 32'(aw_addr_q[2]), 32'h0080);
    chk("t1_len2", 32'(aw_len_q[2]), 32'd7);
    chk("t1_wlast", 32'(wlast_q.size() == 3 && wlast_q[0] == 16 && wlast_q[1] == 32 && wlast_q[2] == 40), 32'd1);
    chk_mem("t1_mem", 16'h0000, 40, 8'h01);
    chk("t1_error", bus.error, 1'b0);
    chk("t1_busy", bus.busy, 1'b0);
    chk("t1_awsize", 32'(bus.m_axi_awsize), 32'd2);
    chk("t1_awburst", 32'(bus.m_axi_awburst), 32'd1);

    // 4 KB page split
    run_xfer(16'h0FF0, 8, 8'h02, 0, 0, 0);
    chk("t2_naw", 32'(aw_addr_q.size()), 32'd2);
    chk("t2_aw0", 32'(aw_addr_q[0]), 32'h0FF0);
    chk("t2_len0", 32'(aw_len_q[0]), 32'd3);
    chk("t2_aw1", 32'(aw_addr_q[1]), 32'h1000);
    chk("t2_len1", 32'(aw_len_q[1]), 32'd3);
    chk("t2_cross", 32'(cross_cnt), 32'd0);
    chk_mem("t2_mem", 16'h0FF0, 8, 8'h02);
    chk("t2_done", 32'(done_cnt), 32'd1);

    // Zero-length start: done next cycle, no traffic
    @(negedge clk);
    bus.cfg_base_addr = 16'h0200;
    bus.cfg_len       = 20'd0;
    bus.start         = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t3_done_pulse", bus.done, 1'b1);
    chk("t3_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("t3_done_low", bus.done, 1'b0);
    run_xfer(16'h0200, 0, 8'h03, 0, 0, 0);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_saw_busy", 32'(saw_busy), 32'd0);
    chk("t3_saw_awvalid", 32'(saw_awvalid), 32'd0);

    // Stream gaps and W backpressure
    run_xfer(16'h0100, 20, 8'h04, 1, 0, 0);
    chk("t4_naw", 32'(aw_addr_q.size()), 32'd2);
    chk("t4_aw1", 32'(aw_addr_q[1]), 32'h0140);
    chk("t4_len1", 32'(aw_len_q[1]), 32'd3);
    chk("t4_wlast", 32'(wlast_q.size() == 2 && wlast_q[0] == 16 && wlast_q[1] == 20), 32'd1);
    chk_mem("t4_mem", 16'h0100, 20, 8'h04);
    chk("t4_done", 32'(done_cnt), 32'd1);

    // SLVERR on the second burst is sticky
    run_xfer(16'h0200, 32, 8'h05, 0, 2, 0);
    chk("t5_done", 32'(done_cnt), 32'd1);
    chk("t5_naw", 32'(aw_addr_q.size()), 32'd2);
    chk("t5_error", bus.error, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_error_sticky", bus.error, 1'b1);
    run_xfer(16'h0403, 4, 8'h06, 0, 0, 0);
    chk("t5_error_clr", bus.error, 1'b0);
    chk("t5_aw_aligned", 32'(aw_addr_q[0]), 32'h0400);
    chk("t5_len", 32'(aw_len_q[0]), 32'd3);
    chk_mem("t5_mem", 16'h0400, 4, 8'h06);

    // Reset in the middle of DATA beats
    run_xfer(16'h0800, 16, 8'h07, 0, 0, 5);
    chk("t6_beats_before", 32'(beats), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_done", bus.done, 1'b0);
    chk("t6_awvalid", bus.m_axi_awvalid, 1'b0);
    chk("t6_bready", bus.m_axi_bready, 1'b0);
    chk("t6_wvalid", bus.m_axi_wvalid, 1'b0);
    chk("t6_tready", bus.s_axis_tready, 1'b0);
    chk("t6_wlast", bus.m_axi_wlast, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    run_xfer(16'h0300, 4, 8'h08, 0, 0, 0);
    chk("t6_new_done", 32'(done_cnt), 32'd1);
    chk("t6_new_naw", 32'(aw_addr_q.size()), 32'd1);
    chk("t6_new_aw", 32'(aw_addr_q[0]), 32'h0300);
    chk("t6_new_len", 32'(aw_len_q[0]), 32'd3);
    chk_mem("t6_new_mem", 16'h0300, 4, 8'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_axi_burst_writer.md
Name: axis_axi_burst_writer

Overview:
- AXI4 write master that drains an AXI-Stream into memory as INCR bursts, starting at a programmed base address for a programmed word count.
- Sits directly upstream of the AXI4 RAM slave. Drives its AW/W/B channels; read channels are not used.
- Serves capture/DMA-style fills from a streaming source into on-chip RAM.

Parameters:
- DATA_WIDTH, 32, AXI and stream data width in bits.
- ADDR_WIDTH, 16, AXI address width; must be >= 12, error at elaboration otherwise.
- STRB_WIDTH, DATA_WIDTH/8, byte lanes; must be a power of two.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant awid value.
- MAX_BURST_LEN, 16, maximum beats per burst, range 1..256.
- LEN_WIDTH, 20, width of the word-count input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_base_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0)
- cfg_len  in  LEN_WIDTH  number of words to write
- start  in  1  single-cycle start request
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky; set on any non-OKAY bresp, cleared on accepted start
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- m_axi_awid  out  ID_WIDTH  = AXI_ID
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  = log2(STRB_WIDTH)
- m_axi_awburst  out  2  = 2'b01 (INCR)
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  DATA_WIDTH  = s_axis_tdata
- m_axi_wstrb  out  STRB_WIDTH  all ones
- m_axi_wlast  out  1
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  ID_WIDTH  ignored
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset: state IDLE. Low: busy, done, error, awvalid, bready, s_axis_tready/wvalid (combinational, therefore low). Address and counters are cleared to 0. Reset mid-burst abandons the transfer; there is no outstanding-transaction tracking.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - start=1 latches addr=cfg_base_addr with low bits cleared, remaining=cfg_len, and clears error.
  - If cfg_len=0: done pulses next cycle, state stays IDLE, no AXI traffic.
  - Otherwise: busy=1 next cycle, state goes to ADDR.
  - start while busy is ignored.
- ADDR:
  - burst = min(remaining, MAX_BURST_LEN, words_to_4k), where words_to_4k = (4096 - addr[11:0]) >> log2(STRB_WIDTH).
  - Registered awvalid=1 with awaddr=addr and awlen=burst-1.
  - awvalid holds stable until awready. On the handshake: beat_cnt=burst-1, state goes to DATA.
- DATA:
  - m_axi_wvalid = s_axis_tvalid.
  - s_axis_tready = m_axi_wready.
  - m_axi_wlast = (beat_cnt==0).
  - These are combinational, zero latency, and gated to 0 outside DATA.
  - Each W handshake decrements beat_cnt. The wlast handshake moves state to RESP with bready=1.
- RESP:
  - On bvalid&bready: error |= (bresp!=2'b00); addr += burst*STRB_WIDTH; remaining -= burst.
  - If remaining is then 0: done=1 for one cycle, busy=0, state goes to IDLE. Otherwise state goes to ADDR.
- Single outstanding burst only; AW for burst n+1 is issued after B of burst n.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Bursts never cross a 4 KB boundary.
- Stream stalls (tvalid=0) simply hold DATA; no timeout.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, the 4 KB boundary constant.
  - State encoding localparams.
- One natural sub-module: axi_burst_len_calc. It is combinational and computes the min(remaining, MAX_BURST_LEN, words_to_4k) burst size. It is reusable by a future stream reader.

Test Plan:
- base=0x0000, len=40, MAX_BURST_LEN=16, slave always ready -> AW at 0x0000/len15, 0x0040/len15, 0x0080/len7. Data equals the stream order; done pulses once; error=0.
- base=0x0FF0, len=8, 32-bit data -> AW 0x0FF0 len3, then 0x1000 len3. No burst crosses 4 KB.
- len=0 with start -> done one cycle later. No awvalid, busy stays 0.
- Random tvalid gaps and wready backpressure, len=20 -> RAM contents match the stream. wlast is asserted only on beats 16 and 20.
- Slave returns bresp=2'b10 on the 2nd burst of len=32 -> transfer completes, error=1 stays set. The next start clears error.
- Assert rst in the middle of the DATA beats of a len=16 transfer -> all outputs low, state IDLE. A new start with len=4 completes normally.
